// File: rtl/muldiv4_pkg.sv
// muldiv4_pkg: state and op encodings plus default operand width shared by the muldiv4 sequencer and step
package muldiv4_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;
    typedef enum logic {OP_MUL = 1'b0, OP_DIV = 1'b1} op_t;
endpackage

// File: rtl/muldiv4_step.sv
// muldiv4_step: one shift-add (MUL) or restoring-subtract (DIV, only with MULDIV4_DIV_EN) iteration
module muldiv4_step
    import muldiv4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
`ifdef MULDIV4_DIV_EN
    input  logic               op,
`endif
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_nxt
);
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
`ifdef MULDIV4_DIV_EN
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] rem_n;
    logic             ge;
    assign rem_s = acc[2*WIDTH-1:WIDTH-1];
    assign ge = rem_s >= {1'b0, opnd};
    assign rem_n = ge ? rem_s[WIDTH-1:0] - opnd : rem_s[WIDTH-1:0];
    assign acc_nxt = op == OP_DIV ? {rem_n, acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
`else
    assign acc_nxt = {sum, acc[WIDTH-1:1]};
`endif
endmodule

// File: rtl/muldiv4_sequencer.sv
// muldiv4_sequencer: start/busy/done iterative MUL/DIV controller; DIV present only with MULDIV4_DIV_EN
module muldiv4_sequencer
    import muldiv4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             err
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic               accept, fault;
`ifdef MULDIV4_DIV_EN
    logic               op_r;
    assign fault = op == OP_DIV && b == '0;
`else
    assign fault = op == OP_DIV;
`endif
    assign accept = state == IDLE && start;
    assign {result_hi, result_lo} = acc;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
        state_nxt = accept ? (fault ? DONE : CALC) :
                    state == CALC ? (count == '0 ? DONE : CALC) :
                    state == DONE ? IDLE : state;
    end
    // acc doubles as the result register so results hold until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opnd  <= '0;
            count <= '0;
            err   <= 1'b0;
`ifdef MULDIV4_DIV_EN
            op_r  <= OP_MUL;
`endif
        end else if (accept) begin
            opnd  <= op == OP_MUL ? a : b;
            count <= CW'(WIDTH - 1);
            err   <= fault;
`ifdef MULDIV4_DIV_EN
            op_r  <= op;
            acc   <= fault ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, op == OP_MUL ? b : a};
`else
            acc   <= fault ? '0 : {{WIDTH{1'b0}}, b};
`endif
        end else if (state == CALC) begin
            acc   <= acc_nxt;
            count <= count - CW'(1);
        end
    end
    muldiv4_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV4_DIV_EN
        .op      (op_r),
`endif
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );
endmodule
